core_acc_arb: RTL and testbench

Round-robin arbiter that shares one accumulation unit between `REQ_NUM` partial-sum producers (MAC array lanes). It grants one lane at a time for a whole accumulation group of `cfg_acc_num` beats, forwards that lane's psums to the accumulator through one register stage, and records the lane ID of each group. When the accumulator reports a finished result, the block returns the ID of the lane that owns it. It sits between the MAC array outputs and the accumulation top.

---
 rtl/core_acc_arb_if.sv | 32 +++
 rtl/core_acc_arb.sv | 170 +++++++++++++++++
 tb/tb_core_acc_arb.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_acc_arb_if.sv
// core_acc_arb_if: lane-side and accumulator-side handshake bundle of the
// accumulation arbiter.
//   req_data/req_valid/req_ready : per-lane psum stream (lane i = req_data[i])
//   acc_idata/acc_idata_valid    : registered psum stream to the accumulator
//   acc_odata_valid              : accumulator result pulse
//   out_id/out_id_valid          : owner lane of the current result
// modport slave  : the arbiter
// modport master : the environment (MAC lanes + accumulator)
interface core_acc_arb_if #(
  parameter int REQ_NUM   = 4,
  parameter int IDATA_BIT = 32,
  parameter int ID_BIT    = $clog2(REQ_NUM)
) ();
  logic [REQ_NUM-1:0][IDATA_BIT-1:0] req_data;
  logic [REQ_NUM-1:0]                req_valid;
  logic [REQ_NUM-1:0]                req_ready;
  logic [IDATA_BIT-1:0]              acc_idata;
  logic                              acc_idata_valid;
  logic                              acc_odata_valid;
  logic [ID_BIT-1:0]                 out_id;
  logic                              out_id_valid;

  modport slave (
    input  req_data, req_valid, acc_odata_valid,
    output req_ready, acc_idata, acc_idata_valid, out_id, out_id_valid
  );

  modport master (
    output req_data, req_valid, acc_odata_valid,
    input  req_ready, acc_idata, acc_idata_valid, out_id, out_id_valid
  );
endinterface

// File: rtl/core_acc_arb.sv
// core_acc_arb: round-robin arbiter sharing one accumulator among REQ_NUM
// psum lanes. A lane is granted for a whole group of cfg_acc_num beats, its
// beats are forwarded through one register stage, and the lane ID of each
// completed group is queued so the accumulator's result can be tagged.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   cfg_acc_num    : beats per group, sampled at grant (0 acts as 1)
//   bus (slave)    : lane handshakes, accumulator input/output, out_id
//   busy           : FSM not idle or groups still owed a result
//   err_underflow  : sticky, result arrived with no group outstanding
module core_acc_arb #(
  parameter int REQ_NUM    = 4,
  parameter int IDATA_BIT  = 32,
  parameter int CDATA_BIT  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_BIT     = $clog2(REQ_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CDATA_BIT-1:0] cfg_acc_num,
  core_acc_arb_if.slave        bus,
  output logic                 busy,
  output logic                 err_underflow
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_e;

  state_e               state_q, state_d;
  logic [ID_BIT-1:0]    grant_q, grant_d;
  logic [ID_BIT-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CDATA_BIT-1:0] num_lat_q, num_lat_d;
  logic [CDATA_BIT-1:0] beat_cnt_q, beat_cnt_d;

  logic [FIFO_DEPTH-1:0][ID_BIT-1:0] fifo_q;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [IDATA_BIT-1:0] acc_idata_q;
  logic                 acc_vld_q;
  logic                 err_q;

  logic                 fifo_empty, fifo_full;
  logic                 hs, last_beat, push, pop;
  logic                 pick_vld;
  logic [ID_BIT-1:0]    pick_id;

  // (base + off) mod REQ_NUM for off < REQ_NUM; REQ_NUM need not be 2^n.
  function automatic logic [ID_BIT-1:0] wrap_add(logic [ID_BIT-1:0] base, int off);
    int s;
    s = int'(base) + off;
    if (s >= REQ_NUM) s = s - REQ_NUM;
    return ID_BIT'(s);
  endfunction

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));

  assign hs        = (state_q == XFER) && bus.req_valid[grant_q];
  assign last_beat = hs && (beat_cnt_q == num_lat_q - CDATA_BIT'(1));
  assign push      = last_beat;
  assign pop       = bus.acc_odata_valid && !fifo_empty;

  // First requester at or after rr_ptr. Scanning offsets from the far end
  // down lets the nearest requester overwrite any farther one.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (bus.req_valid[wrap_add(rr_ptr_q, i)]) begin
        pick_vld = 1'b1;
        pick_id  = wrap_add(rr_ptr_q, i);
      end
    end
  end

  // Next-state logic. A grant is only issued with a free FIFO slot, so the
  // push at the end of the group can never overflow.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    num_lat_d  = num_lat_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld && !fifo_full) begin
          state_d    = XFER;
          grant_d    = pick_id;
          num_lat_d  = (cfg_acc_num == '0) ? CDATA_BIT'(1) : cfg_acc_num;
          beat_cnt_d = '0;
        end
      end
      XFER: begin
        if (hs) begin
          beat_cnt_d = beat_cnt_q + CDATA_BIT'(1);
          if (last_beat) begin
            state_d  = GAP;
            rr_ptr_d = (grant_q == ID_BIT'(REQ_NUM - 1)) ? '0 : grant_q + ID_BIT'(1);
          end
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      num_lat_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      num_lat_q  <= num_lat_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Lane-ID FIFO. Push and pop in the same cycle leave the count alone;
  // the pop still consumes the old head because out_id reads rd_ptr_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= grant_q;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Accumulator input stage: data holds when no beat transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_idata_q <= '0;
      acc_vld_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      acc_vld_q <= hs;
      if (hs) acc_idata_q <= bus.req_data[grant_q];
      if (bus.acc_odata_valid && fifo_empty) err_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < REQ_NUM; g++) begin : g_ready
    assign bus.req_ready[g] = (state_q == XFER) && (grant_q == ID_BIT'(g));
  end

  assign bus.acc_idata       = acc_idata_q;
  assign bus.acc_idata_valid = acc_vld_q;
  assign bus.out_id          = fifo_q[rd_ptr_q];
  assign bus.out_id_valid    = bus.acc_odata_valid && !fifo_empty;
  assign busy                = (state_q != IDLE) || !fifo_empty;
  assign err_underflow       = err_q;
endmodule

// File: tb/tb_core_acc_arb.sv
// tb_core_acc_arb: directed bench for core_acc_arb. Each lane streams words
// tagged {lane, seq}; every observed handshake pushes the expected word onto a
// scoreboard queue that is popped when acc_idata_valid appears one cycle
// later. Grant order and beat timing are checked from the handshake log.
module tb_core_acc_arb;
  localparam int REQ_NUM    = 4;
  localparam int IDATA_BIT  = 32;
  localparam int CDATA_BIT  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int ID_BIT     = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [CDATA_BIT-1:0] cfg_acc_num;
  logic                 busy, err_underflow;

  core_acc_arb_if #(.REQ_NUM(REQ_NUM), .IDATA_BIT(IDATA_BIT), .ID_BIT(ID_BIT)) ifc ();

  core_acc_arb #(
    .REQ_NUM(REQ_NUM), .IDATA_BIT(IDATA_BIT), .CDATA_BIT(CDATA_BIT),
    .FIFO_DEPTH(FIFO_DEPTH), .ID_BIT(ID_BIT)
  ) dut (
    .clk(clk), .rst(rst), .cfg_acc_num(cfg_acc_num), .bus(ifc),
    .busy(busy), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [IDATA_BIT-1:0] exp_q[$];
  int hs_lane[$];
  int hs_cyc[$];
  int seq[REQ_NUM];

  function automatic logic [IDATA_BIT-1:0] lane_word(int l, int s);
    return IDATA_BIT'((l << 24) | s);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_data();
    for (int l = 0; l < REQ_NUM; l++) ifc.req_data[l] = lane_word(l, seq[l]);
  endtask

  // One clock: sample handshakes mid-cycle, log them after the edge, then
  // check the registered accumulator input against the scoreboard.
  task automatic tick();
    logic [REQ_NUM-1:0]   hs;
    logic [IDATA_BIT-1:0] e;
    @(negedge clk);
    hs = rst ? '0 : (ifc.req_valid & ifc.req_ready);
    chk("hs_onehot", 64'($onehot0(hs)), 64'(1));
    @(posedge clk);
    cyc++;
    for (int l = 0; l < REQ_NUM; l++) begin
      if (hs[l]) begin
        exp_q.push_back(lane_word(l, seq[l]));
        hs_lane.push_back(l);
        hs_cyc.push_back(cyc);
        seq[l]++;
      end
    end
    #1;
    drive_data();
    chk("acc_idata_valid", 64'(ifc.acc_idata_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (ifc.acc_idata_valid) chk("acc_idata", 64'(ifc.acc_idata), 64'(e));
    end
  endtask

  task automatic run_until_hs(input int n, input int budget, input string tag);
    int k = 0;
    while (hs_lane.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 64'(hs_lane.size() >= n), 64'(1));
  endtask

  task automatic pop_id(input int exp_id, input string tag);
    ifc.acc_odata_valid = 1'b1;
    #1;
    chk({tag, "_id"}, 64'(ifc.out_id), 64'(exp_id));
    chk({tag, "_vld"}, 64'(ifc.out_id_valid), 64'(1));
    tick();
    ifc.acc_odata_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    logic v1;
    ifc.req_valid       = '0;
    ifc.acc_odata_valid = 1'b0;
    cfg_acc_num         = 8'd4;
    for (int l = 0; l < REQ_NUM; l++) seq[l] = 1;
    drive_data();

    // Reset state
    tick(); tick();
    chk("rst_ready", 64'(ifc.req_ready), 64'(0));
    chk("rst_idata", 64'(ifc.acc_idata), 64'(0));
    chk("rst_ivld", 64'(ifc.acc_idata_valid), 64'(0));
    chk("rst_oidv", 64'(ifc.out_id_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err_underflow), 64'(0));
    rst = 1'b0;

    // Single lane 2, 4-beat group
    ifc.req_valid = 4'b0100;
    tick();
    chk("p1_grant", 64'(ifc.req_ready), 64'(4'b0100));
    b = hs_lane.size();
    run_until_hs(b + 4, 10, "p1_timeout");
    chk("p1_gap_ready", 64'(ifc.req_ready), 64'(0));
    ifc.req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      chk("p1_lane", 64'(hs_lane[b+i]), 64'(2));
      chk("p1_cyc", 64'(hs_cyc[b+i] - hs_cyc[b]), 64'(i));
    end
    tick();
    chk("p1_busy", 64'(busy), 64'(1));
    pop_id(2, "p1_pop");
    chk("p1_busy_after", 64'(busy), 64'(0));

    // Round-robin with all lanes, then FIFO-full backpressure
    rst = 1'b1; tick(); rst = 1'b0;
    cfg_acc_num   = 8'd2;
    ifc.req_valid = 4'b1111;
    b = hs_lane.size();
    run_until_hs(b + 8, 40, "p2_timeout");
    for (int g = 0; g < 4; g++) begin
      for (int j = 0; j < 2; j++) begin
        chk("p2_lane", 64'(hs_lane[b+2*g+j]), 64'(g));
        chk("p2_cyc", 64'(hs_cyc[b+2*g+j] - hs_cyc[b]), 64'(4*g + j));
      end
    end
    repeat (6) tick();
    chk("p3_nogrant", 64'(hs_lane.size()), 64'(b + 8));
    chk("p3_ready", 64'(ifc.req_ready), 64'(0));
    chk("p3_busy", 64'(busy), 64'(1));
    pop_id(0, "p3_pop0");
    run_until_hs(b + 10, 10, "p3_timeout");
    chk("p3_lane5a", 64'(hs_lane[b+8]), 64'(0));
    chk("p3_lane5b", 64'(hs_lane[b+9]), 64'(0));
    ifc.req_valid = '0;
    tick(); tick();
    pop_id(1, "p3_pop1");
    pop_id(2, "p3_pop2");
    pop_id(3, "p3_pop3");
    pop_id(0, "p3_pop4");
    chk("p3_drained", 64'(busy), 64'(0));

    // cfg 0 means 1-beat groups
    cfg_acc_num   = 8'd0;
    ifc.req_valid = 4'b0010;
    b = hs_lane.size();
    run_until_hs(b + 3, 20, "p4_timeout");
    ifc.req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      chk("p4_lane", 64'(hs_lane[b+i]), 64'(1));
      chk("p4_cyc", 64'(hs_cyc[b+i] - hs_cyc[b]), 64'(3*i));
    end
    tick(); tick();
    for (int i = 0; i < 3; i++) pop_id(1, "p4_pop");

    // Bubbles on lane 1 keep the grant; lane 3 waits; cfg change mid-group
    cfg_acc_num   = 8'd3;
    ifc.req_valid = 4'b0010;
    tick();
    b  = hs_lane.size();
    v1 = 1'b1;
    for (int k = 0; k < 20 && hs_lane.size() < b + 3; k++) begin
      ifc.req_valid = {1'b1, 1'b0, v1, 1'b0};
      tick();
      if (hs_lane.size() == b + 1) cfg_acc_num = 8'd1;
      v1 = ~v1;
    end
    chk("p5_count", 64'(hs_lane.size()), 64'(b + 3));
    for (int i = 0; i < 3; i++) begin
      chk("p5_lane", 64'(hs_lane[b+i]), 64'(1));
      chk("p5_cyc", 64'(hs_cyc[b+i] - hs_cyc[b]), 64'(2*i));
    end
    chk("p5_gap_ready", 64'(ifc.req_ready), 64'(0));
    ifc.req_valid = 4'b1000;
    run_until_hs(b + 4, 10, "p5_l3_timeout");
    chk("p5_l3_lane", 64'(hs_lane[b+3]), 64'(3));
    chk("p5_l3_len1", 64'(ifc.req_ready), 64'(0));
    ifc.req_valid = '0;
    tick(); tick();
    pop_id(1, "p5_pop1");
    pop_id(3, "p5_pop3");
    chk("p5_busy", 64'(busy), 64'(0));

    // Push and pop in the same cycle with one entry queued
    cfg_acc_num   = 8'd2;
    ifc.req_valid = 4'b0001;
    b = hs_lane.size();
    run_until_hs(b + 3, 20, "p6_timeout");
    ifc.acc_odata_valid = 1'b1;
    #1;
    chk("p6_id", 64'(ifc.out_id), 64'(0));
    chk("p6_idv", 64'(ifc.out_id_valid), 64'(1));
    chk("p6_lastbeat", 64'(ifc.req_ready), 64'(4'b0001));
    tick();
    ifc.acc_odata_valid = 1'b0;
    ifc.req_valid       = '0;
    chk("p6_hs", 64'(hs_lane.size()), 64'(b + 4));
    tick(); tick();
    chk("p6_busy_one", 64'(busy), 64'(1));
    pop_id(0, "p6_pop");
    chk("p6_busy_empty", 64'(busy), 64'(0));

    // Underflow is sticky
    chk("p6_err0", 64'(err_underflow), 64'(0));
    ifc.acc_odata_valid = 1'b1;
    #1;
    chk("p6_uf_idv", 64'(ifc.out_id_valid), 64'(0));
    tick();
    ifc.acc_odata_valid = 1'b0;
    chk("p6_err1", 64'(err_underflow), 64'(1));
    tick(); tick();
    chk("p6_err_sticky", 64'(err_underflow), 64'(1));
    chk("p6_uf_busy", 64'(busy), 64'(0));

    // Reset in the middle of a 4-beat group
    cfg_acc_num   = 8'd4;
    ifc.req_valid = 4'b1000;
    b = hs_lane.size();
    run_until_hs(b + 2, 20, "p7_timeout");
    rst = 1'b1;
    tick();
    chk("p7_ready", 64'(ifc.req_ready), 64'(0));
    chk("p7_idata", 64'(ifc.acc_idata), 64'(0));
    chk("p7_busy", 64'(busy), 64'(0));
    chk("p7_err", 64'(err_underflow), 64'(0));
    ifc.acc_odata_valid = 1'b1;
    #1;
    chk("p7_empty", 64'(ifc.out_id_valid), 64'(0));
    ifc.acc_odata_valid = 1'b0;
    rst = 1'b0;
    ifc.req_valid = 4'b1001;
    run_until_hs(b + 3, 10, "p7_regrant_timeout");
    chk("p7_first_lane", 64'(hs_lane[b+2]), 64'(0));
    ifc.req_valid = '0;
    tick();
    chk("sb_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
